// File: rtl/boot_pkg.sv
// boot_pkg: shared definitions for the boot loader controller.
//   cmd_e    - host header command encodings (header bits [15:14])
//   state_e  - controller sequencing states
//   CMD_*/CLR_BIT/BASE_* - header field bit positions
package boot_pkg;

    typedef enum logic [1:0] {
        CMD_LOAD_I = 2'b00,
        CMD_LOAD_D = 2'b01,
        CMD_RUN    = 2'b10,
        CMD_HALT   = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_LOAD,
        ST_RUN
    } state_e;

    localparam int unsigned CMD_HI  = 15;
    localparam int unsigned CMD_LO  = 14;
    localparam int unsigned CLR_BIT = 13;
    localparam int unsigned BASE_HI = 8;
    localparam int unsigned BASE_LO = 0;

endpackage

// File: rtl/load_addr_gen.sv
// load_addr_gen: burst address counter plus remaining-word counter.
//   clk, rst   - clock, synchronous active-high reset
//   base_ld    - load base into the address counter, clear wrap flag
//   base       - burst start address
//   max_addr   - highest address of the target memory; wraps to 0 after it
//   cnt_ld     - load remaining count with cnt_m1 + 1
//   cnt_m1     - burst length minus one
//   step       - one word consumed: advance address, decrement remaining
//   addr       - address for the current word
//   wrapped    - current address was reached by wrapping past max_addr
//   last       - current word is the final word of the burst
module load_addr_gen #(
    parameter int unsigned AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          base_ld,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] max_addr,
    input  logic          cnt_ld,
    input  logic [AW-1:0] cnt_m1,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          wrapped,
    output logic          last
);

    logic [AW-1:0] addr_q, addr_d;
    logic          wrap_q, wrap_d;
    logic [AW:0]   rem_q,  rem_d;

    always_comb begin
        addr_d = addr_q;
        wrap_d = wrap_q;
        rem_d  = rem_q;
        if (base_ld) begin
            addr_d = base;
            wrap_d = 1'b0;
        end
        if (cnt_ld) begin
            rem_d = {1'b0, cnt_m1} + (AW+1)'(1);
        end
        if (step) begin
            if (addr_q == max_addr) begin
                addr_d = '0;
                wrap_d = 1'b1;
            end else begin
                addr_d = addr_q + AW'(1);
            end
            rem_d = rem_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            wrap_q <= 1'b0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            wrap_q <= wrap_d;
            rem_q  <= rem_d;
        end
    end

    assign addr    = addr_q;
    assign wrapped = wrap_q;
    assign last    = (rem_q == (AW+1)'(1));

endmodule

// File: rtl/boot_load_ctrl.sv
// boot_load_ctrl: host-facing sequencer that loads instruction/data memory
// over a 16-bit valid/ready link while the core is held in reset, then runs
// the core until a HALT header or the watchdog stops it.
//   clk, rst                 - clock, synchronous active-high reset
//   s_valid/s_ready/s_data   - host word link
//   imem_we/addr/wdata       - instruction memory write port (registered)
//   core_dmem_we/addr/wdata  - core data write port, forwarded only in RUN
//   dmem_we/addr/wdata       - data memory write port
//   core_rst_n, running      - high while in RUN
//   err, timeout             - sticky error flags
//   cycle_cnt                - saturating count of RUN cycles
module boot_load_ctrl
    import boot_pkg::*;
#(
    parameter int unsigned IMEM_AW = 8,
    parameter int unsigned DMEM_AW = 9,
    parameter int unsigned DW      = 16,
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned MAX_RUN = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DW-1:0]      s_data,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [DW-1:0]      imem_wdata,
    input  logic               core_dmem_we,
    input  logic [DMEM_AW-1:0] core_dmem_addr,
    input  logic [DW-1:0]      core_dmem_wdata,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DW-1:0]      dmem_wdata,
    output logic               core_rst_n,
    output logic               running,
    output logic               err,
    output logic               timeout,
    output logic [CNT_W-1:0]   cycle_cnt
);

    localparam logic [DMEM_AW-1:0] IMEM_MAX = DMEM_AW'((1 << IMEM_AW) - 1);
    localparam logic [DMEM_AW-1:0] DMEM_MAX = '1;
    localparam bit                 WD_EN    = (MAX_RUN != 0);
    localparam logic [CNT_W-1:0]   WD_LAST  = CNT_W'(MAX_RUN - 1);

    state_e               state_q, state_d;
    logic                 tgt_dmem_q, tgt_dmem_d;
    logic                 err_q, err_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0]   imem_addr_q, imem_addr_d;
    logic [DW-1:0]        imem_wdata_q, imem_wdata_d;
    logic                 ld_we_q, ld_we_d;
    logic [DMEM_AW-1:0]   ld_addr_q, ld_addr_d;
    logic [DW-1:0]        ld_wdata_q, ld_wdata_d;

    logic                 xfer;
    cmd_e                 cmd;
    logic [DMEM_AW-1:0]   field;
    logic [DMEM_AW-1:0]   base_in;
    logic                 base_ld, cnt_ld, step;
    logic [DMEM_AW-1:0]   ag_addr;
    logic                 ag_wrapped, ag_last;

    assign s_ready = !rst;
    assign xfer    = s_valid && s_ready;
    assign cmd     = cmd_e'(s_data[CMD_HI:CMD_LO]);
    assign field   = DMEM_AW'(s_data[BASE_HI:BASE_LO]);
    // Single counter serves both memories: imem bases are masked here and
    // the wrap point is selected by target below.
    assign base_in = field & ((cmd == CMD_LOAD_D) ? DMEM_MAX : IMEM_MAX);

    load_addr_gen #(
        .AW (DMEM_AW)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .base_ld  (base_ld),
        .base     (base_in),
        .max_addr (tgt_dmem_q ? DMEM_MAX : IMEM_MAX),
        .cnt_ld   (cnt_ld),
        .cnt_m1   (field),
        .step     (step),
        .addr     (ag_addr),
        .wrapped  (ag_wrapped),
        .last     (ag_last)
    );

    always_comb begin
        state_d      = state_q;
        tgt_dmem_d   = tgt_dmem_q;
        err_d        = err_q;
        timeout_d    = timeout_q;
        cnt_d        = cnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        ld_we_d      = 1'b0;
        ld_addr_d    = ld_addr_q;
        ld_wdata_d   = ld_wdata_q;
        base_ld      = 1'b0;
        cnt_ld       = 1'b0;
        step         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    case (cmd)
                        CMD_LOAD_I, CMD_LOAD_D: begin
                            tgt_dmem_d = (cmd == CMD_LOAD_D);
                            base_ld    = 1'b1;
                            state_d    = ST_LEN;
                        end
                        CMD_RUN: begin
                            cnt_d   = '0;
                            state_d = ST_RUN;
                        end
                        default: begin
                            if (s_data[CLR_BIT]) begin
                                err_d     = 1'b0;
                                timeout_d = 1'b0;
                            end
                        end
                    endcase
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    cnt_ld  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    step = 1'b1;
                    if (tgt_dmem_q) begin
                        ld_we_d    = 1'b1;
                        ld_addr_d  = ag_addr;
                        ld_wdata_d = s_data;
                    end else begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = ag_addr[IMEM_AW-1:0];
                        imem_wdata_d = s_data;
                    end
                    if (ag_wrapped) begin
                        err_d = 1'b1;
                    end
                    if (ag_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (xfer) begin
                    if (cmd == CMD_HALT) begin
                        state_d = ST_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (WD_EN && (cnt_q == WD_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tgt_dmem_q   <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
            cnt_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            ld_we_q      <= 1'b0;
            ld_addr_q    <= '0;
            ld_wdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            tgt_dmem_q   <= tgt_dmem_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
            cnt_q        <= cnt_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            ld_we_q      <= ld_we_d;
            ld_addr_q    <= ld_addr_d;
            ld_wdata_q   <= ld_wdata_d;
        end
    end

    assign running    = (state_q == ST_RUN);
    assign core_rst_n = running;
    assign err        = err_q;
    assign timeout    = timeout_q;
    assign cycle_cnt  = cnt_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;

    // Core write port bypasses the registers entirely while running.
    assign dmem_we    = running ? core_dmem_we    : ld_we_q;
    assign dmem_addr  = running ? core_dmem_addr  : ld_addr_q;
    assign dmem_wdata = running ? core_dmem_wdata : ld_wdata_q;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// tb_boot_load_ctrl: self-checking bench for boot_load_ctrl with a
// transaction-level reference model and directed literal checks.
module tb_boot_load_ctrl;

    localparam int unsigned IMEM_AW = 8;
    localparam int unsigned DMEM_AW = 9;
    localparam int unsigned DW      = 16;
    localparam int unsigned CNT_W   = 24;
    localparam int unsigned MAX_RUN = 100;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [DW-1:0]      s_data = '0;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [DW-1:0]      imem_wdata;
    logic               core_dmem_we = 1'b0;
    logic [DMEM_AW-1:0] core_dmem_addr = '0;
    logic [DW-1:0]      core_dmem_wdata = '0;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [DW-1:0]      dmem_wdata;
    logic               core_rst_n;
    logic               running;
    logic               err;
    logic               timeout;
    logic [CNT_W-1:0]   cycle_cnt;

    always #5 clk = ~clk;

    boot_load_ctrl #(
        .IMEM_AW (IMEM_AW),
        .DMEM_AW (DMEM_AW),
        .DW      (DW),
        .CNT_W   (CNT_W),
        .MAX_RUN (MAX_RUN)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .imem_we         (imem_we),
        .imem_addr       (imem_addr),
        .imem_wdata      (imem_wdata),
        .core_dmem_we    (core_dmem_we),
        .core_dmem_addr  (core_dmem_addr),
        .core_dmem_wdata (core_dmem_wdata),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .core_rst_n      (core_rst_n),
        .running         (running),
        .err             (err),
        .timeout         (timeout),
        .cycle_cnt       (cycle_cnt)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the controller must present after each edge,
    // expressed as burst bookkeeping (base + index) rather than counters.
    bit          chk_en = 1'b0;
    bit          m_run, m_err, m_to, m_need_len;
    int          m_left, m_idx, m_base, m_size;
    int unsigned m_cnt;
    bit          e_iwe, e_dwe;
    int          e_iaddr, e_daddr;
    logic [15:0] e_idata, e_ddata;

    always @(posedge clk) begin : model
        int          a;
        bit          stop;
        int unsigned old;
        e_iwe = 1'b0;
        e_dwe = 1'b0;
        if (rst) begin
            m_run = 0; m_err = 0; m_to = 0; m_cnt = 0;
            m_need_len = 0; m_left = 0;
        end else if (m_run) begin
            old = m_cnt;
            if (m_cnt != CNT_MAX) m_cnt++;
            stop = (MAX_RUN != 0) && (old == MAX_RUN - 1);
            if (stop) m_to = 1;
            if (s_valid) begin
                if (s_data[15:14] == 2'b11) stop = 1;
                else m_err = 1;
            end
            if (stop) m_run = 0;
        end else if (m_need_len) begin
            if (s_valid) begin
                m_left = int'(s_data[8:0]) + 1;
                m_idx = 0;
                m_need_len = 0;
            end
        end else if (m_left > 0) begin
            if (s_valid) begin
                a = m_base + m_idx;
                if (a >= m_size) m_err = 1;
                a = a % m_size;
                if (m_size == 512) begin
                    e_dwe = 1; e_daddr = a; e_ddata = s_data;
                end else begin
                    e_iwe = 1; e_iaddr = a; e_idata = s_data;
                end
                m_idx++;
                m_left--;
            end
        end else if (s_valid) begin
            case (s_data[15:14])
                2'b00: begin m_size = 256; m_base = int'(s_data[8:0]) % 256; m_need_len = 1; end
                2'b01: begin m_size = 512; m_base = int'(s_data[8:0]); m_need_len = 1; end
                2'b10: begin m_run = 1; m_cnt = 0; end
                default: if (s_data[13]) begin m_err = 0; m_to = 0; end
            endcase
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_ready", 32'(s_ready), 32'(!rst));
            chk("core_rst_n", 32'(core_rst_n), 32'(m_run));
            chk("running", 32'(running), 32'(m_run));
            chk("err", 32'(err), 32'(m_err));
            chk("timeout", 32'(timeout), 32'(m_to));
            chk("cycle_cnt", 32'(cycle_cnt), m_cnt);
            chk("imem_we", 32'(imem_we), 32'(e_iwe));
            if (e_iwe) begin
                chk("imem_addr", 32'(imem_addr), e_iaddr);
                chk("imem_wdata", 32'(imem_wdata), 32'(e_idata));
            end
            if (m_run) begin
                chk("dmem_we_core", 32'(dmem_we), 32'(core_dmem_we));
                chk("dmem_addr_core", 32'(dmem_addr), 32'(core_dmem_addr));
                chk("dmem_wdata_core", 32'(dmem_wdata), 32'(core_dmem_wdata));
            end else begin
                chk("dmem_we", 32'(dmem_we), 32'(e_dwe));
                if (e_dwe) begin
                    chk("dmem_addr", 32'(dmem_addr), e_daddr);
                    chk("dmem_wdata", 32'(dmem_wdata), 32'(e_ddata));
                end
            end
        end
    end

    task automatic send(input logic [15:0] w);
        s_valid = 1'b1;
        s_data  = w;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = 16'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : stim
        int n;
        int thr;

        repeat (3) @(posedge clk);
        #1;
        chk("rst s_ready", 32'(s_ready), 0);
        chk("rst core_rst_n", 32'(core_rst_n), 0);
        chk("rst err", 32'(err), 0);
        chk("rst cycle_cnt", 32'(cycle_cnt), 0);
        rst = 1'b0;
        #1;
        chk("s_ready up", 32'(s_ready), 1);

        // LOAD_I three words at 0..2
        send(16'h0000); send(16'h0002);
        send(16'hA1A1);
        chk("li we0", 32'(imem_we), 1); chk("li a0", 32'(imem_addr), 0); chk("li d0", 32'(imem_wdata), 32'hA1A1);
        send(16'hB2B2);
        chk("li a1", 32'(imem_addr), 1); chk("li d1", 32'(imem_wdata), 32'hB2B2);
        send(16'hC3C3);
        chk("li a2", 32'(imem_addr), 2); chk("li d2", 32'(imem_wdata), 32'hC3C3);
        chk("li dmem_we", 32'(dmem_we), 0);
        idle(1);
        chk("li done we", 32'(imem_we), 0); chk("li err", 32'(err), 0);

        // LOAD_D wrapping from 0x1FF to 0
        send(16'h41FF); send(16'h0001);
        send(16'h1111);
        chk("ld a0", 32'(dmem_addr), 32'h1FF); chk("ld we0", 32'(dmem_we), 1); chk("ld err0", 32'(err), 0);
        send(16'h2222);
        chk("ld a1", 32'(dmem_addr), 0); chk("ld d1", 32'(dmem_wdata), 32'h2222); chk("ld err1", 32'(err), 1);
        idle(1);
        send(16'hE000);
        chk("clr err", 32'(err), 0);

        // RUN with core write pass-through, HALT after 10 cycles
        send(16'h8000);
        chk("run rst_n", 32'(core_rst_n), 1);
        core_dmem_we = 1'b1; core_dmem_addr = 9'h010; core_dmem_wdata = 16'h1234;
        #1;
        chk("pt we", 32'(dmem_we), 1); chk("pt addr", 32'(dmem_addr), 32'h010); chk("pt data", 32'(dmem_wdata), 32'h1234);
        core_dmem_we = 1'b0;
        idle(9);
        send(16'hC000);
        chk("halt rst_n", 32'(core_rst_n), 0);
        chk("halt cnt", 32'(cycle_cnt), 10);
        idle(3);
        chk("halt cnt hold", 32'(cycle_cnt), 10);

        // Watchdog
        send(16'h8000);
        n = 0;
        while (core_rst_n === 1'b1 && n < 300) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("wd run cycles", n, MAX_RUN);
        chk("wd timeout", 32'(timeout), 1);
        chk("wd running", 32'(running), 0);
        chk("wd cnt", 32'(cycle_cnt), MAX_RUN);

        // Illegal header while running
        send(16'h8000);
        send(16'h0000);
        chk("bad imem_we", 32'(imem_we), 0); chk("bad err", 32'(err), 1); chk("bad running", 32'(running), 1);
        idle(2);
        send(16'hC000);
        send(16'hE000);
        chk("clr2 err", 32'(err), 0); chk("clr2 timeout", 32'(timeout), 0);

        // Reset in the middle of a data burst
        send(16'h4000); send(16'h0002);
        send(16'h5555);
        chk("rb we", 32'(dmem_we), 1); chk("rb d", 32'(dmem_wdata), 32'h5555);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rb after we", 32'(dmem_we), 0); chk("rb running", 32'(running), 0);
        idle(2);
        chk("rb idle we", 32'(dmem_we), 0);
        send(16'h8000);
        chk("rb run hdr", 32'(running), 1);
        send(16'hC000);

        // Full 512-word imem burst from 0x80 wraps twice around 256 words
        send(16'h0080); send(16'h01FF);
        for (int i = 0; i < 512; i++) begin
            send(16'(i ^ 16'h5A00));
            if (i == 127) begin
                chk("ib a127", 32'(imem_addr), 255); chk("ib err127", 32'(err), 0);
            end
            if (i == 128) begin
                chk("ib a128", 32'(imem_addr), 0); chk("ib err128", 32'(err), 1);
            end
        end
        chk("ib last a", 32'(imem_addr), 127);
        idle(1);
        chk("ib idle", 32'(running), 0);
        send(16'hE000);

        // Randomized traffic
        thr = 4;
        for (int c = 0; c < 8000; c++) begin
            if (c % 500 == 0) thr = int'($urandom % 8);
            s_valid         = int'($urandom % 8) < thr;
            s_data          = 16'($urandom);
            core_dmem_we    = 1'($urandom);
            core_dmem_addr  = 9'($urandom);
            core_dmem_wdata = 16'($urandom);
            rst             = ($urandom % 400) == 0;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        rst = 1'b0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
